interrupt_controller: RTL and testbench

- Producer side of the PSW handler-entry path: turns 16 asynchronous level-sensitive IRQ lines into one prioritised interrupt request for the CPU control unit.
- Synchronises the lines and qualifies them against the live PSW (interrupt-enable bit 23, mask bits 15:0).
- Presents the winning priority, which the control unit loads into the PSW as its handler-entry priority.
- Handshakes with the control unit so that each request is taken exactly once.

---
 rtl/interrupt_controller_if.sv | 19 +
 rtl/interrupt_controller.sv | 67 ++++++
 tb/tb_interrupt_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: CPU control-unit handshake bundle for the interrupt controller
//   pswValue             : live PSW (bit 23 interrupt enable, bits 15:0 line mask)
//   interruptAcknowledge : one-cycle pulse, request taken
//   interruptRequest     : eligible interrupt pending
//   interruptPriority    : {1'b0, winning line index}
interface interrupt_controller_if;
  logic [31:0] pswValue;
  logic        interruptAcknowledge;
  logic        interruptRequest;
  logic [4:0]  interruptPriority;
  modport master (
    input  pswValue, interruptAcknowledge,
    output interruptRequest, interruptPriority
  );
  modport slave (
    output pswValue, interruptAcknowledge,
    input  interruptRequest, interruptPriority
  );
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronises 16 IRQ lines and raises one prioritised request to the CPU
//   clock          : system clock, rising edge
//   reset          : asynchronous active-low reset
//   interruptLines : asynchronous level-sensitive IRQ lines
//   pendingLines   : synchronised line levels for readback
//   irq_bus        : PSW input and request/acknowledge handshake
module interrupt_controller #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [15:0]            interruptLines,
  output logic [15:0]            pendingLines,
  interrupt_controller_if.master irq_bus
);
  typedef enum logic [1:0] {IDLE, REQUEST, BLANK} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][15:0] sync_q, sync_d;
  logic        req_q, req_d;
  logic [4:0]  prio_q, prio_d;
  logic [15:0] eligible;
  logic [3:0]  winner;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], interruptLines};
    eligible = irq_bus.pswValue[23] ? (sync_q[SYNC_STAGES-1] & irq_bus.pswValue[15:0]) : 16'h0;
    winner = 4'd0;
    for (int i = 0; i < 16; i++) if (eligible[i]) winner = 4'(i);
    state_d = state_q;
    req_d = req_q;
    prio_d = prio_q;
    case (state_q)
      IDLE: if (|eligible) begin
        state_d = REQUEST;
        req_d = 1'b1;
        prio_d = {1'b0, winner};
      end
      REQUEST: begin
        // acknowledge wins over a same-cycle withdrawal; priority keeps the acknowledged value
        if (irq_bus.interruptAcknowledge) begin
          state_d = BLANK;
          req_d = 1'b0;
        end else if (~|eligible) begin
          state_d = IDLE;
          req_d = 1'b0;
        end else prio_d = {1'b0, winner};
      end
      // one quiet cycle so the handler-entry PSW write is visible before re-evaluation
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync_q <= '0;
      req_q <= 1'b0;
      prio_q <= 5'd0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      req_q <= req_d;
      prio_q <= prio_d;
    end
  end
  assign pendingLines = sync_q[SYNC_STAGES-1];
  assign irq_bus.interruptRequest = req_q;
  assign irq_bus.interruptPriority = prio_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed self-checking bench for interrupt_controller
module tb_interrupt_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [15:0] interruptLines = 16'h0;
  logic [15:0] pendingLines;
  int checks = 0;
  int failures = 0;
  interrupt_controller_if bus ();
  interrupt_controller #(.SYNC_STAGES(2)) dut (
    .clock(clock),
    .reset(reset),
    .interruptLines(interruptLines),
    .pendingLines(pendingLines),
    .irq_bus(bus)
  );
  always #5 clock = ~clock;
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic test_reset;
    bus.pswValue = 32'h0080FFFF;
    bus.interruptAcknowledge = 1'b0;
    interruptLines = 16'h0;
    reset = 1'b0;
    tick(2);
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", bus.interruptRequest); end
    checks++; if (bus.interruptPriority !== 5'd0) begin failures++; $display("FAIL reset_prio got=%0d exp=0", bus.interruptPriority); end
    checks++; if (pendingLines !== 16'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0000", pendingLines); end
    reset = 1'b1;
    tick(2);
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL idle_quiet got=%0b exp=0", bus.interruptRequest); end
  endtask
  task automatic test_basic;
    interruptLines = 16'h0020;
    tick(2);
    checks++; if (pendingLines !== 16'h0020) begin failures++; $display("FAIL basic_pending got=%h exp=0020", pendingLines); end
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL basic_early got=%0b exp=0", bus.interruptRequest); end
    tick(1);
    checks++; if (bus.interruptRequest !== 1'b1) begin failures++; $display("FAIL basic_req got=%0b exp=1", bus.interruptRequest); end
    checks++; if (bus.interruptPriority !== 5'd5) begin failures++; $display("FAIL basic_prio got=%0d exp=5", bus.interruptPriority); end
    bus.interruptAcknowledge = 1'b1;
    tick(1);
    bus.interruptAcknowledge = 1'b0;
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL basic_blank got=%0b exp=0", bus.interruptRequest); end
    checks++; if (bus.interruptPriority !== 5'd5) begin failures++; $display("FAIL basic_hold got=%0d exp=5", bus.interruptPriority); end
    tick(1);
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL basic_idle got=%0b exp=0", bus.interruptRequest); end
    tick(1);
    checks++; if (bus.interruptRequest !== 1'b1) begin failures++; $display("FAIL basic_rereq got=%0b exp=1", bus.interruptRequest); end
    interruptLines = 16'h0;
    tick(4);
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL basic_drop got=%0b exp=0", bus.interruptRequest); end
  endtask
  task automatic test_priority;
    interruptLines = 16'h1008;
    tick(3);
    checks++; if (bus.interruptRequest !== 1'b1) begin failures++; $display("FAIL prio_req got=%0b exp=1", bus.interruptRequest); end
    checks++; if (bus.interruptPriority !== 5'd12) begin failures++; $display("FAIL prio_12 got=%0d exp=12", bus.interruptPriority); end
    interruptLines = 16'h0008;
    tick(3);
    checks++; if (bus.interruptPriority !== 5'd3) begin failures++; $display("FAIL prio_3 got=%0d exp=3", bus.interruptPriority); end
    interruptLines = 16'h4008;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checks++; if (bus.interruptRequest !== 1'b1) begin failures++; $display("FAIL upg_req_%0d got=%0b exp=1", i, bus.interruptRequest); end
      checks++; if (bus.interruptPriority !== 5'd3) begin failures++; $display("FAIL upg_pre_%0d got=%0d exp=3", i, bus.interruptPriority); end
    end
    tick(1);
    checks++; if (bus.interruptRequest !== 1'b1) begin failures++; $display("FAIL upg_req got=%0b exp=1", bus.interruptRequest); end
    checks++; if (bus.interruptPriority !== 5'd14) begin failures++; $display("FAIL upg_14 got=%0d exp=14", bus.interruptPriority); end
    interruptLines = 16'h0;
    tick(4);
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL prio_drop got=%0b exp=0", bus.interruptRequest); end
  endtask
  task automatic test_mask;
    bus.pswValue = 32'h0000FFFF;
    interruptLines = 16'h0080;
    tick(4);
    checks++; if (pendingLines !== 16'h0080) begin failures++; $display("FAIL mask_pending got=%h exp=0080", pendingLines); end
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL mask_ie_off got=%0b exp=0", bus.interruptRequest); end
    bus.pswValue = 32'h00800080;
    tick(1);
    checks++; if (bus.interruptRequest !== 1'b1) begin failures++; $display("FAIL mask_ie_on got=%0b exp=1", bus.interruptRequest); end
    checks++; if (bus.interruptPriority !== 5'd7) begin failures++; $display("FAIL mask_prio got=%0d exp=7", bus.interruptPriority); end
    bus.pswValue = 32'h00000080;
    tick(1);
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL mask_ie_clr got=%0b exp=0", bus.interruptRequest); end
    tick(1);
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL mask_idle got=%0b exp=0", bus.interruptRequest); end
    bus.pswValue = 32'h0080FF7F;
    tick(2);
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL mask_bit got=%0b exp=0", bus.interruptRequest); end
    bus.pswValue = 32'h0080FFFF;
    tick(1);
    checks++; if (bus.interruptRequest !== 1'b1) begin failures++; $display("FAIL mask_unmask got=%0b exp=1", bus.interruptRequest); end
  endtask
  task automatic test_collision;
    interruptLines = 16'h0;
    bus.pswValue = 32'h0000FFFF;
    bus.interruptAcknowledge = 1'b1;
    tick(1);
    bus.interruptAcknowledge = 1'b0;
    bus.pswValue = 32'h0080FFFF;
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL coll_blank got=%0b exp=0", bus.interruptRequest); end
    checks++; if (bus.interruptPriority !== 5'd7) begin failures++; $display("FAIL coll_hold got=%0d exp=7", bus.interruptPriority); end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL coll_norereq_%0d got=%0b exp=0", i, bus.interruptRequest); end
    end
    bus.interruptAcknowledge = 1'b1;
    tick(1);
    bus.interruptAcknowledge = 1'b0;
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL idle_ack_req got=%0b exp=0", bus.interruptRequest); end
    checks++; if (bus.interruptPriority !== 5'd7) begin failures++; $display("FAIL idle_ack_prio got=%0d exp=7", bus.interruptPriority); end
    interruptLines = 16'h0200;
    tick(3);
    checks++; if (bus.interruptPriority !== 5'd9) begin failures++; $display("FAIL idle_ack_after got=%0d exp=9", bus.interruptPriority); end
  endtask
  task automatic test_reset_mid;
    checks++; if (bus.interruptRequest !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0b exp=1", bus.interruptRequest); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL rmid_req got=%0b exp=0", bus.interruptRequest); end
    checks++; if (bus.interruptPriority !== 5'd0) begin failures++; $display("FAIL rmid_prio got=%0d exp=0", bus.interruptPriority); end
    checks++; if (pendingLines !== 16'h0) begin failures++; $display("FAIL rmid_pending got=%h exp=0000", pendingLines); end
    #1;
    reset = 1'b1;
    tick(2);
    checks++; if (bus.interruptRequest !== 1'b0) begin failures++; $display("FAIL rmid_early got=%0b exp=0", bus.interruptRequest); end
    tick(1);
    checks++; if (bus.interruptRequest !== 1'b1) begin failures++; $display("FAIL rmid_rereq got=%0b exp=1", bus.interruptRequest); end
    checks++; if (bus.interruptPriority !== 5'd9) begin failures++; $display("FAIL rmid_prio9 got=%0d exp=9", bus.interruptPriority); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_priority;
    test_mask;
    test_collision;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
